// File: rtl/bcd_scan_display.sv
// Two-digit multiplexed seven-segment driver. BCD digits are captured into a
// shadow pair on load and committed to the display pair only at the start of a
// frame, so a frame never mixes old and new digits. One shared active-low
// segment bus is scanned across two active-low digit enables, with dead time
// between digits.
//
// state | meaning
// ------+----------------------------------------------------------
// GAP0  | dead time before tens slot; its last cycle is the commit edge
// TENS  | tens digit lit (blanked when zero and BLANK_LZ is set)
// GAP1  | dead time between tens and ones
// ONES  | ones digit lit, never blanked
module bcd_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int GAP      = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  output logic [6:0] seg_n,
  output logic [1:0] dig_n,
  output logic       pending,
  output logic       frame_tick
);

  localparam int MAXN = (SCAN_DIV > GAP) ? SCAN_DIV : GAP;
  localparam int CW   = $clog2(MAXN + 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [6:0]    SEG_OFF    = 7'b1111111;
  localparam logic [1:0]    DIG_OFF    = 2'b11;

  typedef enum logic [1:0] {GAP0, TENS, GAP1, ONES} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_last;
  logic [3:0]    sh_t, sh_o;
  logic [3:0]    d_t, d_o, d_t_nx, d_o_nx;
  logic          commit;
  logic          pending_nx, tick_nx;
  logic [6:0]    seg_nx;
  logic [1:0]    dig_nx;

  // BCD to active-low segments, bit6 = g ... bit0 = a; 10..15 show a dash
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Slot sequencing: the counter runs 0..N-1 and the last count forces the move
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    cnt_last = ((state == TENS) || (state == ONES)) ? DIGIT_LAST : GAP_LAST;
    if (cnt == cnt_last) begin
      cnt_nx = '0;
      case (state)
        GAP0:    state_nx = TENS;
        TENS:    state_nx = GAP1;
        GAP1:    state_nx = ONES;
        default: state_nx = GAP0;
      endcase
    end
  end

  // Commit and registered-output next values; outputs follow the next state so
  // the first cycle of a slot already shows that slot
  always_comb begin
    commit     = (state == GAP0) && (cnt == cnt_last);
    d_t_nx     = d_t;
    d_o_nx     = d_o;
    pending_nx = pending;
    if (commit) begin
      // a load coinciding with the commit bypasses the shadow pair
      d_t_nx     = load ? tens_in : sh_t;
      d_o_nx     = load ? ones_in : sh_o;
      pending_nx = 1'b0;
    end else if (load) begin
      pending_nx = 1'b1;
    end
    tick_nx = commit;
    seg_nx  = SEG_OFF;
    dig_nx  = DIG_OFF;
    case (state_nx)
      TENS: begin
        if (!((BLANK_LZ != 0) && (d_t_nx == 4'd0))) begin
          seg_nx = decode(d_t_nx);
          dig_nx = 2'b01;
        end
      end
      ONES: begin
        seg_nx = decode(d_o_nx);
        dig_nx = 2'b10;
      end
      default: begin
        seg_nx = SEG_OFF;
        dig_nx = DIG_OFF;
      end
    endcase
  end

  // State, counter and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GAP0;
      cnt   <= '0;
      d_t   <= 4'd0;
      d_o   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      d_t   <= d_t_nx;
      d_o   <= d_o_nx;
    end
  end

  // Shadow pair: last load before a commit wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_t <= 4'd0;
      sh_o <= 4'd0;
    end else if (load) begin
      sh_t <= tens_in;
      sh_o <= ones_in;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= SEG_OFF;
      dig_n      <= DIG_OFF;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= seg_nx;
      dig_n      <= dig_nx;
      pending    <= pending_nx;
      frame_tick <= tick_nx;
    end
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed two-digit seven-segment driver for the 2-digit adder datapath. It sits directly downstream of the binary-to-BCD converter and consumes its tens/ones BCD digits. Digits are captured through a load strobe and committed only at frame boundaries, so the display never tears. It scans one shared, active-low segment bus across two active-low digit enables, with a dead-time gap between digits.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each digit is lit per frame; legal range ≥ 2.
- GAP, 4: dead-time cycles after each digit slot with both digits off; legal range ≥ 1.
- BLANK_LZ, 1: 1 = blank the tens digit when it is 0.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  one-cycle capture strobe for tens_in/ones_in.
- tens_in  in  4  BCD tens digit from the converter.
- ones_in  in  4  BCD ones digit from the converter.
- seg_n  out  7  active-low segments; bit0 = a … bit6 = g; registered.
- dig_n  out  2  active-low digit enables; [1] = tens, [0] = ones; registered.
- pending  out  1  captured value is waiting for the next frame commit; registered.
- frame_tick  out  1  one-cycle pulse on the first cycle of each tens slot; registered.

## Operation
- State machine: GAP0 → TENS → GAP1 → ONES → GAP0.
  - TENS and ONES each last SCAN_DIV cycles; GAP0 and GAP1 each last GAP cycles.
  - A slot counter runs 0…N−1 and forces the transition at N−1.
  - Frame length = 2·(SCAN_DIV+GAP) cycles.
- Registers:
  - Shadow pair (sh_t, sh_o) is written on any cycle load=1.
  - Display pair (d_t, d_o) drives decode.
- Capture: load=1 sets pending=1 and overwrites the shadow pair. When several loads arrive before a commit, the last one wins.
- Commit edge = the GAP0→TENS transition edge.
  - Normal case: display pair ← shadow pair, pending ← 0.
  - If load=1 on the commit edge, the display pair takes tens_in/ones_in directly and pending stays 0.
- Decode, seg_n values listed as g..a:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any value 10–15 decodes to dash, 0111111.
- Output per state:
  - TENS: dig_n = 01, seg_n = decode(d_t). If BLANK_LZ=1 and d_t=0, dig_n = 11 and seg_n = 1111111.
  - ONES: dig_n = 10, seg_n = decode(d_o). The ones digit is never blanked.
  - GAP0/GAP1: dig_n = 11, seg_n = 1111111.
- Reset (asynchronous, any time, including mid-slot), immediately:
  - state = GAP0, counter = 0
  - shadow pair = 0, display pair = 0
  - pending = 0, frame_tick = 0, dig_n = 11, seg_n = 1111111

## Timing
- All outputs are registered and computed from next-state on the same edge as the transition.
- Therefore, the first cycle a state is entered already shows that state's outputs.
- After rst_n rises, GAP0 lasts GAP cycles, then the first TENS cycle begins with frame_tick=1.
- Commit latency, from a load edge to the new value appearing on seg_n:
  - Minimum 0 cycles after the commit edge: load on the commit edge bypasses the shadow.
  - Maximum one full frame.
- pending rises on the edge after load and falls on the commit edge.
- frame_tick is high only in the first TENS cycle. It pulses even when the tens digit is blanked.
- tens_in and ones_in are sampled only when load=1 and are ignored otherwise.

## Test plan
All scenarios use SCAN_DIV=4, GAP=1, BLANK_LZ=1, giving a 10-cycle frame.
- Reset/idle: while rst_n=0, require dig_n=11, seg_n=1111111, pending=0. After release, 1 GAP0 cycle, then TENS with frame_tick=1. Tens is blanked (dig_n=11) for 4 cycles, then GAP1 for 1, then ONES with dig_n=10, seg_n=1000000 for 4.
- Load tens=1, ones=5 in the 2nd ONES cycle: pending=1 through the end of the frame and the display is unchanged. At the next TENS, tens shows 1111001 and ones shows 0010010, with pending=0 and frame_tick=1.
- Load 3/7, then load 9/2 in the same frame: the next frame shows 0010000/0100100, and 3/7 never appears on seg_n.
- Load 4/8 on the commit edge: the TENS slot that begins on that edge shows 0011001 and the following ONES slot shows 0000000. pending never asserts.
- Load 12/15: both digits show 0111111. Then load 0/9: tens is blanked and ones shows 0010000.
- Assert rst_n=0 in the 3rd TENS cycle while displaying 7/7 with pending=1: outputs go to 11/1111111 with pending=0 without waiting for a clock edge. After release, the ones digit shows 0 (1000000).
